// File: rtl/xillybus_arb_pkg.sv
// Shared definitions for the Xillybus read-stream arbiter:
// header layout and arbiter FSM states.
package xillybus_arb_pkg;

    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_SRC_LSB   = 16;
    localparam int         HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN
    } arb_state_t;

    function automatic logic [31:0] make_hdr(
        input logic [1:0]  src,
        input logic [15:0] len
    );
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        h[HDR_SRC_LSB +: 2]   = src;
        h[HDR_LEN_LSB +: 16]  = len;
        return h;
    endfunction

endpackage

// File: rtl/xillybus_rd_arbiter_if.sv
// Requester and host read-stream signals of the arbiter.
// master = arbiter side, slave = requesters plus host.
interface xillybus_rd_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_pkt_rdy;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_rden;
    logic               rd_rden;
    logic [31:0]        rd_data;
    logic               rd_empty;
    logic               rd_eof;
    logic               rd_open;

    modport master (
        input  req_pkt_rdy, req_data, rd_rden, rd_open,
        output req_rden, rd_data, rd_empty, rd_eof
    );

    modport slave (
        output req_pkt_rdy, req_data, rd_rden, rd_open,
        input  req_rden, rd_data, rd_empty, rd_eof
    );
endinterface

// File: rtl/xillybus_out_fifo.sv
// Synchronous non-show-ahead FIFO with flush; rd_data is
// registered and updates the cycle after an accepted read.
module xillybus_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_wr, do_rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign do_wr = wr_en & ~full & ~flush;
    assign do_rd = rd_en & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) begin
                rd_data <= mem[rp];
                rp      <= rp + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/xillybus_rd_arbiter.sv
// Round-robin packet arbiter: frames each requester packet with
// a header and streams it into the host read FIFO.
module xillybus_rd_arbiter
    import xillybus_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int PKT_WORDS   = 8,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                  bus_clk,
    input  logic                  rst,
    xillybus_rd_arbiter_if.master bus
);
    localparam int GW = $clog2(NREQ);

    arb_state_t    state, state_n;
    logic [GW-1:0] grant, grant_n;
    logic [GW-1:0] rr, rr_n;
    logic [15:0]   cnt, cnt_n;
    logic [GW-1:0] pick, idx;
    logic          found;
    logic          push;
    logic [31:0]   push_data;
    logic [NREQ-1:0] rden;
    logic          f_full, f_empty;

    // First ready requester at or after rr, wrapping.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr + GW'(k);
            if (!found && bus.req_pkt_rdy[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            rr    <= rr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        rr_n      = rr;
        cnt_n     = cnt;
        push      = 1'b0;
        push_data = '0;
        rden      = '0;
        unique case (state)
            ST_IDLE: begin
                if (bus.rd_open && found) begin
                    grant_n = pick;
                    rr_n    = pick + 1'b1;
                    cnt_n   = 16'(PKT_WORDS - 1);
                    state_n = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!bus.rd_open) begin
                    state_n = ST_DRAIN;
                end else if (!f_full) begin
                    push      = 1'b1;
                    push_data = make_hdr(2'(grant), 16'(PKT_WORDS));
                    state_n   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.rd_open) begin
                    state_n = ST_DRAIN;
                end else if (!f_full) begin
                    rden[grant] = 1'b1;
                    push        = 1'b1;
                    push_data   = bus.req_data[grant*32 +: 32];
                    if (cnt == '0) state_n = ST_IDLE;
                    else           cnt_n   = cnt - 16'd1;
                end
            end
            ST_DRAIN: begin
                // Discard the rest so the requester stays packet-aligned.
                rden[grant] = 1'b1;
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 16'd1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    xillybus_out_fifo #(
        .DEPTH(OFIFO_DEPTH)
    ) u_fifo (
        .clk    (bus_clk),
        .rst    (rst),
        .flush  (~bus.rd_open),
        .wr_en  (push),
        .wr_data(push_data),
        .rd_en  (bus.rd_rden),
        .rd_data(bus.rd_data),
        .full   (f_full),
        .empty  (f_empty)
    );

    assign bus.req_rden = rden;
    assign bus.rd_empty = f_empty | ~bus.rd_open;
    assign bus.rd_eof   = 1'b0;
endmodule

// File: tb/tb_xillybus_rd_arbiter.sv
// Scoreboard bench for xillybus_rd_arbiter: modelled requester
// queues feed the DUT, a monitor checks every host read.
module tb_xillybus_rd_arbiter;
    localparam int NREQ = 4;
    localparam int PW   = 8;

    logic bus_clk = 1'b0;
    logic rst     = 1'b1;

    xillybus_rd_arbiter_if #(.NREQ(NREQ)) bus();

    xillybus_rd_arbiter #(
        .NREQ(NREQ), .PKT_WORDS(PW), .OFIFO_DEPTH(4)
    ) dut (
        .bus_clk(bus_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 bus_clk = ~bus_clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] rq [NREQ][$];
    logic [NREQ-1:0] rden_neg = '0;
    int pulses [NREQ] = '{0, 0, 0, 0};
    logic pop_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int src);
        return {8'hA5, 6'b0, 2'(src), 16'(PW)};
    endfunction

    // Requester model: show-ahead queues popped on req_rden.
    always @(posedge bus_clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (rden_neg[i] && rq[i].size() > 0)
                void'(rq[i].pop_front());
            bus.req_pkt_rdy[i] = (rq[i].size() >= PW);
            bus.req_data[i*32 +: 32] =
                (rq[i].size() > 0) ? rq[i][0] : 32'h0;
        end
    end

    // Monitor: one-hot pop strobes and scoreboard on host reads.
    always @(negedge bus_clk) begin
        if (pop_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", bus.rd_data, 32'hxxxxxxxx);
            end else begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
        pop_q = bus.rd_rden & ~bus.rd_empty & ~rst;
        rden_neg = bus.req_rden;
        chk("rden_onehot", 32'($countones(bus.req_rden) <= 1), 32'd1);
        for (int i = 0; i < NREQ; i++)
            if (bus.req_rden[i]) pulses[i]++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge bus_clk);
            #2;
        end
    endtask

    task automatic load(input int r, input logic [31:0] base);
        for (int j = 0; j < PW; j++) rq[r].push_back(base + 32'(j));
    endtask

    task automatic expect_pkt(input int r, input logic [31:0] base);
        exp_q.push_back(hdr(r));
        for (int j = 0; j < PW; j++) exp_q.push_back(base + 32'(j));
    endtask

    task automatic wait_sb(input string name);
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_pulses(input int r, input int base, input int n);
        for (int c = 0; c < 100 && pulses[r] - base < n; c++) tick();
        chk("pulse_wait", 32'(pulses[r] - base), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    int base;

    initial begin
        bus.rd_rden = 1'b0;
        bus.rd_open = 1'b0;
        tick(3);
        chk("rst_empty", 32'(bus.rd_empty), 32'd1);
        chk("rst_data",  bus.rd_data, 32'h0);
        chk("rst_rden",  32'(bus.req_rden), 32'h0);
        chk("rst_eof",   32'(bus.rd_eof), 32'h0);
        rst = 1'b0;
        tick();

        // Single requester 2.
        bus.rd_open = 1'b1;
        bus.rd_rden = 1'b1;
        load(2, 32'h200);
        expect_pkt(2, 32'h200);
        wait_sb("single_pkt");
        tick(3);
        chk("single_empty", 32'(bus.rd_empty), 32'd1);

        // All four ready: round-robin 0,1,2,3,0.
        do_reset();
        bus.rd_open = 1'b0;
        for (int i = 0; i < NREQ; i++) load(i, 32'h1000 * (i + 1));
        load(0, 32'h1100);
        for (int i = 0; i < NREQ; i++) expect_pkt(i, 32'h1000 * (i + 1));
        expect_pkt(0, 32'h1100);
        tick();
        bus.rd_open = 1'b1;
        wait_sb("round_robin");

        // Host stalled: FIFO fills with header plus 3 words.
        do_reset();
        bus.rd_rden = 1'b0;
        base = pulses[0];
        load(0, 32'h300);
        tick(20);
        chk("stall_pulses", 32'(pulses[0] - base), 32'd3);
        chk("stall_nonempty", 32'(bus.rd_empty), 32'd0);
        expect_pkt(0, 32'h300);
        bus.rd_rden = 1'b1;
        wait_sb("stall_release");
        chk("stall_total", 32'(pulses[0] - base), 32'd8);

        // Read strobe on empty FIFO changes nothing.
        tick(3);
        chk("empty_flag", 32'(bus.rd_empty), 32'd1);
        bus.rd_rden = 1'b0;
        tick();
        bus.rd_rden = 1'b1;
        tick(2);
        chk("empty_rd_hold", bus.rd_data, 32'h307);
        chk("empty_no_rden", 32'(bus.req_rden), 32'h0);

        // Close mid-payload: drain the rest, then fresh header.
        bus.rd_rden = 1'b0;
        base = pulses[1];
        load(1, 32'h400);
        wait_pulses(1, base, 3);
        tick(5);
        bus.rd_open = 1'b0;
        tick(12);
        chk("drain_pulses", 32'(pulses[1] - base), 32'd8);
        chk("drain_empty", 32'(bus.rd_empty), 32'd1);
        load(1, 32'h500);
        expect_pkt(1, 32'h500);
        bus.rd_rden = 1'b1;
        bus.rd_open = 1'b1;
        wait_sb("reopen_pkt");

        // Reset mid-payload; rr restarts at requester 0.
        bus.rd_rden = 1'b0;
        base = pulses[2];
        load(2, 32'h600);
        wait_pulses(2, base, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(bus.rd_empty), 32'd1);
        chk("mid_rst_data",  bus.rd_data, 32'h0);
        chk("mid_rst_rden",  32'(bus.req_rden), 32'h0);
        tick(2);
        rst = 1'b0;
        rq[2].delete();
        load(3, 32'h800);
        load(0, 32'h700);
        expect_pkt(0, 32'h700);
        expect_pkt(3, 32'h800);
        bus.rd_rden = 1'b1;
        wait_sb("post_rst_rr");
        chk("final_eof", 32'(bus.rd_eof), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/xillybus_rd_arbiter.md
XILLYBUS_RD_ARBITER -- requirements
Module: xillybus_rd_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of result requesters (fixed at 4 this revision).
REQ-002 Parameter PKT_WORDS, default 8, payload words per packet (1..65535).
REQ-003 Parameter OFIFO_DEPTH, default 4, output FIFO depth in words (power of 2).
REQ-004 bus_clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_pkt_rdy  in  NREQ  bit i: requester i holds at least one full packet.
REQ-007 req_data  in  NREQx32  show-ahead word of requester i, bits [32i+31:32i].
REQ-008 req_rden  out  NREQ  pop strobe to requester i.
REQ-009 rd_rden  in  1  read strobe from the host read stream.
REQ-010 rd_data  out  32  host read data.
REQ-011 rd_empty  out  1  output FIFO empty.
REQ-012 rd_eof  out  1  end-of-file to the host stream.
REQ-013 rd_open  in  1  host read stream open.

Function
REQ-014 Output FIFO is standard (non-show-ahead): rd_data is valid the cycle after rd_rden with rd_empty=0; rd_rden while rd_empty=1 is ignored, with no state change.
REQ-015 rd_eof is constant 0.
REQ-016 FSM states: IDLE, HDR, PAYLOAD, DRAIN.
REQ-017 IDLE -> HDR when rd_open=1 and any req_pkt_rdy=1; latch grant g = first ready index at or after rr_ptr, modulo NREQ.
REQ-018 rr_ptr := (g+1) mod NREQ on grant, so service is strict round-robin.
REQ-019 HDR: on a cycle with FIFO not full, push header {8'hA5, 6'b0, g[1:0], PKT_WORDS[15:0]} and go to PAYLOAD with word counter = PKT_WORDS-1.
REQ-020 PAYLOAD: each cycle with FIFO not full, assert req_rden[g] and push req_data[g] in the same cycle; at counter 0 go to IDLE, else decrement.
REQ-021 No push occurs when the FIFO is full, even if rd_rden pops that cycle; a simultaneous push and pop with FIFO not full leaves occupancy unchanged.
REQ-022 At most one req_rden bit is high per cycle, and never outside PAYLOAD/DRAIN.
REQ-023 rd_open=0 in HDR or PAYLOAD -> DRAIN, keeping the counter (full count if from HDR).
REQ-024 DRAIN: pop req_rden[g] every cycle, discarding data; at counter 0 go to IDLE; rd_open reasserting does not exit DRAIN early.
REQ-025 While rd_open=0 the output FIFO is flushed every cycle (rd_empty=1) and no grants are issued.
REQ-026 Back-to-back packets: IDLE costs exactly one cycle between packets.

Reset
REQ-027 On rst: state=IDLE, rr_ptr=0, counter=0, FIFO empty, rd_empty=1, rd_data=0, req_rden=0, rd_eof=0.
REQ-028 Reset mid-packet abandons the packet; the requester realignment is its own responsibility.

Structure
REQ-029 Package xillybus_arb_pkg holds the header magic 8'hA5, the header field positions, and the FSM state enum.
REQ-030 Sub-module xillybus_out_fifo (sync FIFO, OFIFO_DEPTH words, full/empty/flush) holds the output buffer; arbitration and FSM stay in xillybus_rd_arbiter.
REQ-031 Target size is 150-300 RTL lines total.

Verification
REQ-032 Only requester 2 ready, data 0x200..0x207, rd_rden=1, rd_open=1 -> rd_data sequence 0xA5020008, 0x200..0x207, then rd_empty=1.
REQ-033 All four requesters ready continuously -> header src fields 0,1,2,3,0 in order, with no payload interleaving.
REQ-034 rd_rden=0 with requester 0 ready -> FIFO holds 4 words (header plus 3 payload), req_rden stays 0 thereafter; releasing rd_rden yields all 9 words with no loss or duplication.
REQ-035 rd_open dropped after 3 payload words -> 5 further req_rden pulses to the same requester, rd_empty=1; after reopen, a fresh header appears first.
REQ-036 rst pulsed mid-PAYLOAD -> all outputs at reset values within the same cycle; the next grant starts from requester 0.
REQ-037 rd_rden pulsed while rd_empty=1 -> no change to rd_data, occupancy or FSM.
